// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store traffic.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_BUSY = 2'd1,
        F_BUSY = 2'd2
    } state_t;

    localparam logic [7:0] STARVE_LIM   = 8'(STARVE_MAX);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_starve_cnt;
    logic [7:0] r_timeout_cnt;
    logic       w_data_req;
    logic       w_fetch_req;
    logic       w_grant_data;
    logic       w_grant_fetch;
    logic       w_done;
    logic       w_abort;

    // A requester whose ack is high this cycle has just been served and must not re-issue.
    assign w_data_req  = (mem_rd | mem_wr) & ~mem_ack;
    assign w_fetch_req = if_req & ~if_ack;

    assign ram_req   = (r_state != IDLE);
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = (mem_rd | mem_wr) & ~mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        w_done        = 1'b0;
        w_abort       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fetch_req && (!w_data_req || r_starve_cnt == STARVE_LIM)) begin
                    w_next_state  = F_BUSY;
                    w_grant_fetch = 1'b1;
                end else if (w_data_req) begin
                    w_next_state = D_BUSY;
                    w_grant_data = 1'b1;
                end
            end
            D_BUSY, F_BUSY: begin
                // A memory ack landing on the last allowed cycle still counts as success.
                if (ram_ack) begin
                    w_next_state = IDLE;
                    w_done       = 1'b1;
                end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                    w_next_state = IDLE;
                    w_abort      = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            if_rdata      <= '0;
            mem_rdata     <= '0;
            if_ack        <= 1'b0;
            mem_ack       <= 1'b0;
            err           <= 1'b0;
            r_starve_cnt  <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            err     <= 1'b0;
            if (w_grant_data) begin
                ram_addr      <= mem_addr;
                ram_wdata     <= mem_wdata;
                ram_we        <= mem_wr;
                r_timeout_cnt <= '0;
                if (w_fetch_req && r_starve_cnt != STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + 8'd1;
                end
            end else if (w_grant_fetch) begin
                ram_addr      <= if_addr;
                ram_we        <= 1'b0;
                r_timeout_cnt <= '0;
                r_starve_cnt  <= '0;
            end else if (w_done || w_abort) begin
                r_timeout_cnt <= '0;
                err           <= w_abort;
                // Stores leave the load data register untouched.
                if (r_state == F_BUSY) begin
                    if_ack   <= 1'b1;
                    if_rdata <= w_abort ? '0 : ram_rdata;
                end else begin
                    mem_ack <= 1'b1;
                    if (!ram_we) begin
                        mem_rdata <= w_abort ? '0 : ram_rdata;
                    end
                end
            end else if (r_state != IDLE) begin
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end
        end
    end

endmodule
